// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module      : mem_access_ctrl
// Description : Multicycle-CPU memory port controller. It latches one request
//               and handshakes it with a memory over mem_ready, with a timeout.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              IorD,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [ADDR_W-1:0] pc_addr,
    input  logic [ADDR_W-1:0] alu_addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_ACCESS = 2'd1;
    localparam logic [1:0] c_RESP   = 2'd2;

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_CNT_MAX  = CNT_W'(TIMEOUT);

    logic [1:0]        r_state_q,    w_state_d;
    logic              r_is_write_q, w_is_write_d;
    logic [ADDR_W-1:0] r_addr_q,     w_addr_d;
    logic [DATA_W-1:0] r_wdata_q,    w_wdata_d;
    logic [CNT_W-1:0]  r_cnt_q,      w_cnt_d;
    logic [DATA_W-1:0] r_rdata_q,    w_rdata_d;
    logic              r_err_q,      w_err_d;

    logic              w_req_valid;
    logic              w_req_conflict;
    logic              w_timeout;
    logic [ADDR_W-1:0] w_sel_addr;

    assign w_req_valid    = MemRead ^ MemWrite;
    assign w_req_conflict = MemRead & MemWrite;
    assign w_sel_addr     = IorD ? alu_addr : pc_addr;
    // The last permitted wait cycle ends without mem_ready: give up.
    assign w_timeout      = !mem_ready && (r_cnt_q == c_CNT_LAST);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q    <= c_IDLE;
            r_is_write_q <= 1'b0;
            r_addr_q     <= '0;
            r_wdata_q    <= '0;
            r_cnt_q      <= '0;
            r_rdata_q    <= '0;
            r_err_q      <= 1'b0;
        end else begin
            r_state_q    <= w_state_d;
            r_is_write_q <= w_is_write_d;
            r_addr_q     <= w_addr_d;
            r_wdata_q    <= w_wdata_d;
            r_cnt_q      <= w_cnt_d;
            r_rdata_q    <= w_rdata_d;
            r_err_q      <= w_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_d = r_state_q;
        case (r_state_q)
            c_IDLE: begin
                if (w_req_valid) begin
                    w_state_d = c_ACCESS;
                end
            end
            c_ACCESS: begin
                if (mem_ready || w_timeout) begin
                    w_state_d = c_RESP;
                end
            end
            c_RESP: begin
                w_state_d = c_IDLE;
            end
            default: begin
                w_state_d = c_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_is_write_d = r_is_write_q;
        w_addr_d     = r_addr_q;
        w_wdata_d    = r_wdata_q;
        w_cnt_d      = r_cnt_q;
        w_rdata_d    = r_rdata_q;
        w_err_d      = r_err_q;
        case (r_state_q)
            c_IDLE: begin
                if (w_req_valid) begin
                    w_is_write_d = MemWrite;
                    w_addr_d     = w_sel_addr;
                    w_wdata_d    = wdata;
                    w_cnt_d      = '0;
                    w_err_d      = 1'b0;
                end else if (w_req_conflict) begin
                    w_err_d = 1'b1;
                end
            end
            c_ACCESS: begin
                if (mem_ready) begin
                    if (!r_is_write_q) begin
                        w_rdata_d = mem_rdata;
                    end
                end else begin
                    if (r_cnt_q != c_CNT_MAX) begin
                        w_cnt_d = r_cnt_q + 1'b1;
                    end
                    if (w_timeout) begin
                        w_err_d = 1'b1;
                    end
                end
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        mem_addr  = r_addr_q;
        mem_wdata = r_wdata_q;
        case (r_state_q)
            c_IDLE: begin
                // Idle shows the live request so memory sees the address early.
                mem_addr  = w_sel_addr;
                mem_wdata = wdata;
            end
            c_ACCESS: begin
                busy   = 1'b1;
                mem_rd = !r_is_write_q;
                mem_wr = r_is_write_q;
            end
            c_RESP: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign rdata = r_rdata_q;
    assign err   = r_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module      : tb_mem_access_ctrl
// Description : Self-checking bench for mem_access_ctrl (vector table plus
//               scoreboard of completion results, and reset corner cases).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int TIMEOUT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic [7:0] pc_addr;
    logic [7:0] alu_addr;
    logic [7:0] wdata;
    logic [7:0] mem_addr;
    logic [7:0] mem_wdata;
    logic       mem_rd;
    logic       mem_wr;
    logic       mem_ready;
    logic [7:0] mem_rdata;
    logic [7:0] rdata;
    logic       busy;
    logic       done;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rd;
        logic       wr;
        logic       iord;
        logic [7:0] pc;
        logic [7:0] alu;
        logic [7:0] wd;
        int         wait_n;
        logic [7:0] mrd;
        logic [7:0] exp_rdata;
        logic       exp_err;
        int         exp_strobes;
    } vec_t;

    typedef struct {
        logic [7:0] rdata;
        logic       err;
    } exp_t;

    vec_t vecs[9];
    exp_t sb[$];

    mem_access_ctrl #(
        .ADDR_W (8),
        .DATA_W (8),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .IorD     (IorD),
        .MemRead  (MemRead),
        .MemWrite (MemWrite),
        .pc_addr  (pc_addr),
        .alu_addr (alu_addr),
        .wdata    (wdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rd   (mem_rd),
        .mem_wr   (mem_wr),
        .mem_ready(mem_ready),
        .mem_rdata(mem_rdata),
        .rdata    (rdata),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input vec_t v);
        logic [7:0] exp_addr;
        int         strobes;
        int         c;
        bit         seen;
        exp_t       e;
        exp_addr = v.iord ? v.alu : v.pc;
        strobes  = 0;
        seen     = 1'b0;

        IorD = v.iord; pc_addr = v.pc; alu_addr = v.alu; wdata = v.wd;
        MemRead = v.rd; MemWrite = v.wr; mem_ready = 1'b0;
        #1;
        chk("idle_addr", 32'(mem_addr), 32'(exp_addr));
        chk("idle_wdata", 32'(mem_wdata), 32'(v.wd));
        chk("idle_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);

        if (v.rd && v.wr) begin
            tick();
            MemRead = 1'b0; MemWrite = 1'b0;
            chk("conflict_err", 32'(err), 32'(v.exp_err));
            chk("conflict_busy", 32'(busy), 32'd0);
            chk("conflict_strobes", 32'({mem_rd, mem_wr}), 32'd0);
            chk("conflict_done", 32'(done), 32'd0);
            tick();
            chk("conflict_done2", 32'(done), 32'd0);
            chk("conflict_busy2", 32'(busy), 32'd0);
            return;
        end

        sb.push_back('{rdata: v.exp_rdata, err: v.exp_err});
        tick();
        c = 0;
        while (!seen && c < TIMEOUT + 5) begin
            if (done === 1'b1) begin
                seen = 1'b1;
                MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
                e = sb.pop_front();
                chk("done_rdata", 32'(rdata), 32'(e.rdata));
                chk("done_err", 32'(err), 32'(e.err));
                chk("done_busy", 32'(busy), 32'd1);
                chk("done_strobes", 32'({mem_rd, mem_wr}), 32'd0);
                chk("strobe_cycles", 32'(strobes), 32'(v.exp_strobes));
                tick();
                chk("after_done", 32'(done), 32'd0);
                chk("after_busy", 32'(busy), 32'd0);
                chk("after_rdata", 32'(rdata), 32'(e.rdata));
                chk("after_err", 32'(err), 32'(e.err));
            end else begin
                chk("acc_busy", 32'(busy), 32'd1);
                chk("acc_err", 32'(err), 32'd0);
                chk("acc_strobe", 32'({mem_rd, mem_wr}), 32'({v.rd, v.wr}));
                chk("acc_addr", 32'(mem_addr), 32'(exp_addr));
                chk("acc_wdata", 32'(mem_wdata), 32'(v.wd));
                strobes++;
                mem_ready = (c == v.wait_n);
                mem_rdata = (c == v.wait_n) ? v.mrd : 8'($urandom);
                // Junk request activity that the controller must ignore.
                MemRead  = c[0];
                MemWrite = ~c[0];
                IorD     = ~v.iord;
                pc_addr  = ~v.pc;
                alu_addr = ~v.alu;
                wdata    = ~v.wd;
                tick();
                c++;
            end
        end
        if (!seen) begin
            errors++;
            $display("FAIL done_wait actual=no_done expected=done_within_%0d", TIMEOUT + 5);
            MemRead = 1'b0; MemWrite = 1'b0; mem_ready = 1'b0;
            void'(sb.pop_front());
            repeat (3) tick();
        end
    endtask

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h99, 8'h00, 0,  8'hA5, 8'hA5, 1'b0, 1};
        vecs[1] = '{1'b0, 1'b1, 1'b1, 8'h55, 8'h3C, 8'h7E, 3,  8'h11, 8'hA5, 1'b0, 4};
        vecs[2] = '{1'b1, 1'b0, 1'b0, 8'h20, 8'h21, 8'h00, 15, 8'h77, 8'hA5, 1'b1, 15};
        vecs[3] = '{1'b1, 1'b0, 1'b1, 8'h01, 8'h44, 8'h00, 2,  8'h5A, 8'h5A, 1'b0, 3};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h30, 8'h31, 8'h00, 0,  8'h00, 8'h5A, 1'b1, 0};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 8'h81, 8'h82, 8'hC3, 14, 8'h22, 8'h5A, 1'b0, 15};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h90, 8'h6D, 8'h00, 14, 8'h3E, 8'h3E, 1'b0, 15};
        vecs[7] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'hE0, 8'h0F, 20, 8'h33, 8'h3E, 1'b1, 15};
        vecs[8] = '{1'b1, 1'b0, 1'b0, 8'hF0, 8'h0F, 8'h00, 1,  8'hFF, 8'hFF, 1'b0, 2};

        rst = 1'b1; IorD = 1'b0; MemRead = 1'b0; MemWrite = 1'b0;
        pc_addr = '0; alu_addr = '0; wdata = '0; mem_ready = 1'b0; mem_rdata = '0;
        tick();
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_rdata", 32'(rdata), 32'd0);
        chk("rst_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            run_vec(vecs[i]);
        end

        // Reset in the second ACCESS cycle of a read aborts it silently.
        IorD = 1'b0; pc_addr = 8'h66; MemRead = 1'b1; MemWrite = 1'b0;
        mem_ready = 1'b0; mem_rdata = 8'h99;
        tick();
        MemRead = 1'b0;
        chk("abort_acc1_rd", 32'(mem_rd), 32'd1);
        tick();
        chk("abort_acc2_rd", 32'(mem_rd), 32'd1);
        chk("abort_acc2_addr", 32'(mem_addr), 32'h66);
        rst = 1'b1;
        mem_ready = 1'b1;
        tick();
        rst = 1'b0;
        mem_ready = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_strobes", 32'({mem_rd, mem_wr}), 32'd0);
        chk("abort_rdata", 32'(rdata), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_err", 32'(err), 32'd0);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("abort_no_done", 32'(done), 32'd0);
            chk("abort_idle", 32'(busy), 32'd0);
        end
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
